// File: rtl/wallace_multiplier_pipe.sv
// wallace_multiplier_pipe
//   Pipelined WIDTH x WIDTH multiplier built from a carry-save (Wallace)
//   reduction tree and a final Kogge-Stone carry-lookahead adder. Each beat
//   selects unsigned or two's-complement (Baugh-Wooley) operation.
//
//   Pipeline: operand capture -> partial products + first CSA levels ->
//   remaining CSA levels (two rows) -> carry-lookahead add into product_o.
//   A beat accepted at edge N is presented after edge N+3 when not stalled.
//
//   Handshake: a beat moves on any edge where valid and ready are both high.
//   All stages advance together whenever the output register is empty or
//   being drained (advance = !valid_o | ready_i); otherwise everything holds.
//   ready_o equals advance and never depends on valid_i.
//
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     valid_i, ready_o    operand beat handshake
//     op1_i, op2_i        multiplicand, multiplier (WIDTH bits)
//     signed_i            1 = two's-complement beat, 0 = unsigned
//     valid_o, ready_i    product beat handshake
//     product_o           2*WIDTH-bit product, held while stalled
//     busy_o              any pipeline stage holds a beat
//
//   Optional feature (macro WALLACE_APPROX_TRUNC_EN): partial-product bits in
//   columns below APPROX_COLS are dropped before reduction, so the low
//   APPROX_COLS product bits read as zero. Without the macro the product is
//   exact and APPROX_COLS has no effect.

module wallace_multiplier_pipe #(
   parameter int WIDTH       = 8,
   parameter int APPROX_COLS = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [WIDTH-1:0]   op1_i,
   input  logic [WIDTH-1:0]   op2_i,
   input  logic               signed_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [2*WIDTH-1:0] product_o,
   output logic               busy_o
);

   localparam int PW  = 2 * WIDTH;
   // WIDTH partial-product rows plus one row carrying the Baugh-Wooley constants.
   localparam int NR0 = WIDTH + 1;
   // Row budget at the end of the first reduction stage: ceil(2*WIDTH/3)+1.
   localparam int NR1 = (PW + 2) / 3 + 1;

   typedef logic [NR0-1:0][PW-1:0] rows_t;

   function automatic int rows_after(input int n, input int target);
      int m;
      m = n;
      while (m > target) m = m - m / 3;
      return m;
   endfunction

   function automatic int levels_for(input int n, input int target);
      int m;
      int l;
      m = n;
      l = 0;
      while (m > target) begin
         m = m - m / 3;
         l = l + 1;
      end
      return l;
   endfunction

   localparam int N1 = rows_after(NR0, NR1);
   localparam int L1 = levels_for(NR0, NR1);
   localparam int L2 = levels_for(N1, 2);

   if (WIDTH < 4 || WIDTH > 32 || APPROX_COLS < 0 || APPROX_COLS > WIDTH) begin : g_bad_param
      $error("wallace_multiplier_pipe: WIDTH or APPROX_COLS out of range");
   end

   // One or more 3:2 levels. Each level compresses every full group of three
   // rows into a sum row and a carry row; leftover rows pass through. Result
   // rows are compacted towards index 0. Carries past the MSB are dropped,
   // which is exactly the modulo 2^(2*WIDTH) behaviour wanted.
   function automatic rows_t csa_reduce(input rows_t rin, input int n_in, input int n_lvl);
      rows_t r;
      rows_t nr;
      int    n;
      int    g;
      r = rin;
      n = n_in;
      for (int l = 0; l < NR0; l++) begin
         if (l < n_lvl) begin
            nr = '0;
            g  = n / 3;
            for (int i = 0; i < NR0 / 3; i++) begin
               if (i < g) begin
                  nr[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
                  nr[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) |
                               (r[3*i+1] & r[3*i+2])) << 1;
               end
            end
            for (int j = 0; j < NR0; j++) begin
               if (j >= 3 * g && j < n) nr[j-g] = r[j];
            end
            r = nr;
            n = n - g;
         end
      end
      return r;
   endfunction

   logic                     advance;
   logic                     v0, v1, v2;
   logic [WIDTH-1:0]         a_q, b_q;
   logic                     s_q;
   logic                     pp_bit;
   rows_t                    pp_rows, red1, red2_in, red2;
   logic [N1-1:0][PW-1:0]    s1_d, s1_r;
   logic [1:0][PW-1:0]       s2_d, s2_r;
   logic [PW-1:0]            ks_p, ks_g, ks_gp, sum;

   assign advance = ~valid_o | ready_i;
   assign ready_o = advance;
   assign busy_o  = v0 | v1 | v2 | valid_o;

   // Stage 1: partial products and first CSA levels.
   // Baugh-Wooley: bits pairing exactly one sign bit are inverted, and the
   // correction constants sit at columns WIDTH and 2*WIDTH-1.
   always_comb begin
      pp_rows = '0;
      pp_bit  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            pp_bit = a_q[j] & b_q[i];
            if (s_q && ((i == WIDTH - 1) != (j == WIDTH - 1))) pp_bit = ~pp_bit;
`ifdef WALLACE_APPROX_TRUNC_EN
            if (i + j < APPROX_COLS) pp_bit = 1'b0;
`endif
            pp_rows[i][i+j] = pp_bit;
         end
      end
      pp_rows[WIDTH][WIDTH]  = s_q;
      pp_rows[WIDTH][PW-1]   = s_q;
      red1 = csa_reduce(pp_rows, NR0, L1);
      for (int i = 0; i < N1; i++) s1_d[i] = red1[i];
   end

   // Stage 2: finish the reduction down to two rows.
   always_comb begin
      red2_in = '0;
      for (int i = 0; i < N1; i++) red2_in[i] = s1_r[i];
      red2 = csa_reduce(red2_in, N1, L2);
      for (int i = 0; i < 2; i++) s2_d[i] = red2[i];
   end

   // Stage 3: Kogge-Stone prefix carry computation; ks_g[i] ends as the
   // group generate of bits [i:0], i.e. the carry into bit i+1.
   always_comb begin
      ks_p  = s2_r[0] ^ s2_r[1];
      ks_g  = s2_r[0] & s2_r[1];
      ks_gp = ks_p;
      for (int d = 1; d < PW; d = d * 2) begin
         ks_g  = ks_g | (ks_gp & (ks_g << d));
         ks_gp = ks_gp & (ks_gp << d);
      end
      sum = ks_p ^ (ks_g << 1);
   end

   // Data registers load only behind a valid beat, so operand X never
   // reaches the datapath; the valid chain alone decides what is presented.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v0        <= 1'b0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         valid_o   <= 1'b0;
         product_o <= '0;
      end else if (advance) begin
         v0      <= valid_i & ready_o;
         v1      <= v0;
         v2      <= v1;
         valid_o <= v2;
         if (valid_i) begin
            a_q <= op1_i;
            b_q <= op2_i;
            s_q <= signed_i;
         end
         if (v0) s1_r <= s1_d;
         if (v1) s2_r <= s2_d;
         if (v2) product_o <= sum;
      end
   end

endmodule

// File: doc/wallace_multiplier_pipe.md
Name: wallace_multiplier_pipe

Overview:
- Parametrised, pipelined successor to the 8x8 combinational CSA/Wallace multiplier.
- Configurable operand width and per-operation signed/unsigned mode (Baugh-Wooley).
- Valid/ready handshake on input and output; three register stages: partial-product/first CSA levels, remaining CSA levels, final carry-lookahead add.
- Sits in the arithmetic datapath as a drop-in throughput-1 multiplier with backpressure.

Parameters:
- WIDTH, 8, operand width in bits; legal values 4..32.
- APPROX_COLS, 4, number of low product columns discarded when the approximate feature is compiled in; legal values 0..WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  operand beat valid.
- ready_o  output  1  block can accept a beat this cycle.
- op1_i  input  WIDTH  multiplicand.
- op2_i  input  WIDTH  multiplier.
- signed_i  input  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
- valid_o  output  1  product beat valid.
- ready_i  input  1  downstream accepts the product.
- product_o  output  2*WIDTH  product, held stable while valid_o=1 and ready_i=0.
- busy_o  output  1  OR of all stage valid bits.

Behaviour:
- Reset (rst_i=1 at a clock edge): all stage valid bits cleared; valid_o=0, product_o=0, busy_o=0. ready_o=1 in the first cycle after reset. Reset mid-operation discards every in-flight beat; no product from those beats is ever presented.
- Global advance: advance = !valid_o | ready_i. ready_o = advance (combinational, no dependence on valid_i).
- Input transfer when valid_i & ready_o. Output transfer when valid_o & ready_i.
- When advance=1, all three stages shift by one, bubbles included. valid for stage 1 = valid_i & ready_o.
- When advance=0, every stage register and product_o hold their values. No data loss, no duplication.
- Latency: a beat accepted at edge N appears on valid_o/product_o after edge N+3 when no stall occurs. Each stall cycle adds one cycle.
- Throughput: one beat per cycle with ready_i held at 1.
- Stage 1 datapath:
  - AND partial products.
  - In signed mode, Baugh-Wooley form: the row/column sign bits are inverted, and constant 1s are added at columns WIDTH and 2*WIDTH-1.
  - 3:2 CSA reduction until at most ceil(2*WIDTH/3)+1 rows remain.
  - signed_i is registered alongside the operands.
- Stage 2: continue CSA reduction to exactly two rows of 2*WIDTH bits.
- Stage 3: carry-lookahead add of the two rows. Result truncated to 2*WIDTH bits, so the product is exact modulo 2^(2*WIDTH), and no overflow is possible.
- Simultaneous input accept and output drain in the same cycle is legal. The pipeline stays full.
- Mode may change every beat; each beat uses its own registered signed_i.
- X on op1_i/op2_i/signed_i when valid_i=0 must not propagate to valid_o.

Optional Feature:
- Macro: WALLACE_APPROX_TRUNC_EN.
- Defined: partial-product bits in columns 0..APPROX_COLS-1 are forced to 0 before reduction. No carries originate from those columns; product_o[APPROX_COLS-1:0]=0. Applies in both signed and unsigned modes (Baugh-Wooley constants are not truncated when their column is >= APPROX_COLS). Latency and handshake are unchanged.
- Undefined: exact product; APPROX_COLS is ignored.

Test Plan:
- Unsigned, WIDTH=8, no macro: op1=8'hFF, op2=8'hFF, signed_i=0 -> product_o=16'hFE01 exactly 3 cycles after acceptance; op1=8'hFF, op2=8'h02 -> 16'h01FE.
- Signed, no macro: op1=8'hFF, op2=8'h02, signed_i=1 -> 16'hFFFE; op1=8'h80, op2=8'h80 -> 16'h4000; op1=8'h80, op2=8'h7F -> 16'hC080.
- Back-to-back and backpressure: stream 10 beats with valid_i=1 and alternating signed_i. Hold ready_i=0 for 4 cycles mid-stream -> ready_o=0 during the stall, product_o stable. All 10 products are delivered in order with no loss or duplication, and throughput returns to 1/cycle after release.
- Reset mid-operation: accept 3 beats, assert rst_i for one cycle -> valid_o=0, product_o=0, busy_o=0 on the next cycle; none of the 3 products ever appear.
- Approximate, macro defined, APPROX_COLS=4: op1=8'hFF, op2=8'hFF unsigned -> 16'hFDD0; op1=8'h03, op2=8'h01 -> 16'h0000.
- Parametric sweep: WIDTH=4, 13, 32 with 1000 random beats per mode and random ready_i -> every product equals the reference model's exact product.
